// File: rtl/br_pred.sv
// br_pred: fetch-side bimodal branch predictor.
//   A table of 2^IDX_W two-bit saturating counters indexed by pc[IDX_W+1:2]
//   predicts conditional branches in fetch. The table is trained from the
//   resolve stage, where actual = ex_pr_taken ^ ex_pr_miss.
//   After reset an init sweep writes CNT_INIT into every entry, one per
//   cycle. Prediction stays off until the sweep is done.
// Optional feature: define BP_GSHARE_EN to XOR a global history register
//   into both the predict index and the train index (gshare).
// Ports:
//   clk, rst      core clock; asynchronous active-high reset
//   if_pc, if_ir  fetch-stage PC and instruction
//   pr_taken      prediction for the branch in fetch (combinational)
//   pr_addr       predicted next PC (combinational)
//   bp_ready      init sweep done, predictor live
//   ex_valid      resolved conditional branch present
//   ex_pc         PC of the resolved branch
//   ex_pr_taken   prediction that travelled with the resolved branch
//   ex_pr_miss    resolve-stage mispredict flag
//   stall         pipeline stall; blocks training
module br_pred #(
  parameter int unsigned IDX_W    = 6,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] if_pc,
  input  logic [31:0] if_ir,
  output logic        pr_taken,
  output logic [63:0] pr_addr,
  output logic        bp_ready,
  input  logic        ex_valid,
  input  logic [63:0] ex_pc,
  input  logic        ex_pr_taken,
  input  logic        ex_pr_miss,
  input  logic        stall
);

  localparam int unsigned        DEPTH    = 1 << IDX_W;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [6:0]         OP_BR    = 7'b1100011;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] init_idx;
  logic [1:0]       cnt [DEPTH];

  logic             upd;
  logic             actual;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       cnt_rd;
  logic [1:0]       cnt_old;
  logic [1:0]       cnt_new;
  logic             is_br;
  logic [63:0]      offs;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  // Next state: sweep every entry once, then stay live until reset
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (init_idx == LAST_IDX) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    bp_ready = 1'b0;
    if (state == S_RUN) bp_ready = 1'b1;
  end

  // Sweep pointer; restarts from 0 on every reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  init_idx <= '0;
    else if (state == S_INIT) init_idx <= init_idx + IDX_W'(1);
  end

  // Training is only accepted once live; updates during the sweep are dropped
  assign upd    = bp_ready & ex_valid & ~stall;
  assign actual = ex_pr_taken ^ ex_pr_miss;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  // Global history of accepted outcomes, non-speculative
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ghr <= '0;
    else if (upd) ghr <= {ghr[IDX_W-2:0], actual};
  end

  // Train index uses the pre-shift history
  assign rd_idx = if_pc[IDX_W+1:2] ^ ghr;
  assign wr_idx = ex_pc[IDX_W+1:2] ^ ghr;
`else
  assign rd_idx = if_pc[IDX_W+1:2];
  assign wr_idx = ex_pc[IDX_W+1:2];
`endif

  // Saturating counter update
  assign cnt_old = cnt[wr_idx];
  always_comb begin
    cnt_new = cnt_old;
    if (actual) begin
      if (cnt_old != 2'b11) cnt_new = cnt_old + 2'd1;
    end else begin
      if (cnt_old != 2'b00) cnt_new = cnt_old - 2'd1;
    end
  end

  // Counter table: no reset, cleared by the sweep; written at the edge so a
  // same-cycle read of the same entry sees the old value
  always_ff @(posedge clk) begin
    if (state == S_INIT) cnt[init_idx] <= CNT_INIT;
    else if (upd)        cnt[wr_idx]   <= cnt_new;
  end

  // Prediction, combinational from the fetch stage
  assign cnt_rd   = cnt[rd_idx];
  assign is_br    = (if_ir[6:0] == OP_BR);
  assign pr_taken = bp_ready & is_br & cnt_rd[1];

  // B-type immediate, sign-extended to 64 bits
  assign offs    = {{51{if_ir[31]}}, if_ir[31], if_ir[7], if_ir[30:25], if_ir[11:8], 1'b0};
  assign pr_addr = pr_taken ? (if_pc + offs) : (if_pc + 64'd4);

  // Fields that never affect the prediction or the index
  logic unused_bits;
  assign unused_bits = ^{if_ir[24:12], ex_pc[63:IDX_W+2], ex_pc[1:0], cnt_rd[0]};

endmodule

// File: tb/tb_br_pred.sv
// tb_br_pred: self-checking bench for br_pred (IDX_W = 6, CNT_INIT = 1).
//   A behavioural model (array of integer counters, sweep cycle count, history
//   as an integer) predicts the outputs; one compare process checks every
//   cycle, plus literal expectations for the directed scenarios.
module tb_br_pred;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] if_pc = 64'd0;
  logic [31:0] if_ir = 32'd0;
  logic        pr_taken;
  logic [63:0] pr_addr;
  logic        bp_ready;
  logic        ex_valid = 1'b0;
  logic [63:0] ex_pc = 64'd0;
  logic        ex_pr_taken = 1'b0;
  logic        ex_pr_miss = 1'b0;
  logic        stall = 1'b0;

  int total = 0;
  int bad   = 0;

  br_pred dut (
    .clk         (clk),
    .rst         (rst),
    .if_pc       (if_pc),
    .if_ir       (if_ir),
    .pr_taken    (pr_taken),
    .pr_addr     (pr_addr),
    .bp_ready    (bp_ready),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_pr_taken (ex_pr_taken),
    .ex_pr_miss  (ex_pr_miss),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_cnt [64];
  int m_sweep = 0;
  bit m_ready = 1'b0;
  int m_ghr   = 0;

  function automatic int tidx(input logic [63:0] pc);
    int i;
    i = int'((pc / 64'd4) % 64'd64);
`ifdef BP_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  function automatic int sat(input int v);
    if (v > 3) return 3;
    if (v < 0) return 0;
    return v;
  endfunction

  function automatic longint br_off(input logic [31:0] ir);
    longint v;
    v = 0;
    if (ir[31]) v = v - 4096;
    if (ir[7])  v = v + 2048;
    v = v + longint'(ir[30:25]) * 32;
    v = v + longint'(ir[11:8]) * 2;
    return v;
  endfunction

  function automatic logic [31:0] enc_br(input int off);
    logic [12:0] imm;
    imm = 13'(off);
    return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sweep <= 0;
      m_ready <= 1'b0;
      m_ghr   <= 0;
    end else if (!m_ready) begin
      m_sweep <= m_sweep + 1;
      if (m_sweep == 63) begin
        for (int k = 0; k < 64; k++) m_cnt[k] <= 1;
        m_ready <= 1'b1;
      end
    end else if (ex_valid && !stall) begin
      m_cnt[tidx(ex_pc)] <= sat(m_cnt[tidx(ex_pc)] + ((ex_pr_taken ^ ex_pr_miss) ? 1 : -1));
      m_ghr <= ((m_ghr * 2) + int'(ex_pr_taken ^ ex_pr_miss)) % 64;
    end
  end

  // ---------------- compare process ----------------
  bit          chk_en    = 1'b0;
  bit          lit_valid = 1'b0;
  string       lit_name  = "";
  bit          lit_taken = 1'b0;
  logic [63:0] lit_addr  = 64'd0;
  bit          lit_ready = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit          e_t;
      logic [63:0] e_a;
      e_t = m_ready && (if_ir[6:0] == 7'h63) && (m_cnt[tidx(if_pc)] >= 2);
      e_a = e_t ? if_pc + 64'(br_off(if_ir)) : if_pc + 64'd4;
      chk("model_ready", 64'(bp_ready), 64'(m_ready));
      chk("model_taken", 64'(pr_taken), 64'(e_t));
      chk("model_addr",  pr_addr, e_a);
      if (lit_valid) begin
        chk({lit_name, "_ready"}, 64'(bp_ready), 64'(lit_ready));
        chk({lit_name, "_taken"}, 64'(pr_taken), 64'(lit_taken));
        chk({lit_name, "_addr"},  pr_addr, lit_addr);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    lit_valid = 1'b0;
  endtask

  task automatic lit(input string n, input bit t, input logic [63:0] a, input bit r);
    lit_valid = 1'b1;
    lit_name  = n;
    lit_taken = t;
    lit_addr  = a;
    lit_ready = r;
  endtask

  task automatic upd(input logic [63:0] pc, input bit t, input bit m);
    ex_valid    = 1'b1;
    ex_pc       = pc;
    ex_pr_taken = t;
    ex_pr_miss  = m;
    tick();
    ex_valid    = 1'b0;
  endtask

  // Release reset and watch the full sweep with a branch sitting in fetch
  task automatic sweep(input string tag);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_pc = 64'h100;
    if_ir = enc_br(64);
    for (int i = 0; i <= 64; i++) begin
      lit(tag, 1'b0, 64'h104, i == 64);
      tick();
    end
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    sweep("sweep");

    lit("cold", 1'b0, 64'h104, 1'b1);
    tick();

    upd(64'h100, 1'b1, 1'b0);
    upd(64'h100, 1'b1, 1'b0);
`ifdef BP_GSHARE_EN
    // history is now 000011: pc 0x100 hits entry 3 (cold), pc 0x108 hits entry 1
    lit("gs_100", 1'b0, 64'h104, 1'b1);
    tick();
    if_pc = 64'h108;
    lit("gs_108", 1'b1, 64'h148, 1'b1);
    tick();
`else
    lit("trained", 1'b1, 64'h140, 1'b1);
    tick();
    if_ir = enc_br(-8);
    lit("neg_off", 1'b1, 64'hF8, 1'b1);
    tick();

    if_ir = enc_br(64);
    repeat (5) upd(64'h100, 1'b1, 1'b0);
    upd(64'h100, 1'b1, 1'b1);
    lit("sat_nt1", 1'b1, 64'h140, 1'b1);
    tick();
    upd(64'h100, 1'b0, 1'b0);
    lit("sat_nt2", 1'b0, 64'h104, 1'b1);
    tick();

    // update and fetch of the same entry in one cycle: old value is read
    if_pc       = 64'h200;
    ex_valid    = 1'b1;
    ex_pc       = 64'h100;
    ex_pr_taken = 1'b1;
    ex_pr_miss  = 1'b0;
    lit("hazard_old", 1'b0, 64'h204, 1'b1);
    tick();
    ex_valid = 1'b0;
    lit("hazard_new", 1'b1, 64'h240, 1'b1);
    tick();

    stall = 1'b1;
    repeat (3) upd(64'h200, 1'b0, 1'b0);
    stall = 1'b0;
    lit("stall", 1'b1, 64'h240, 1'b1);
    tick();

    if_ir = 32'h00B50533;
    lit("non_br", 1'b0, 64'h204, 1'b1);
    tick();
`endif

    // reset in the middle of the sweep restarts it from index 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (30) tick();
    sweep("resweep");
    if_pc = 64'h200;
    if_ir = enc_br(64);
    lit("after_resweep", 1'b0, 64'h204, 1'b1);
    tick();

    // randomized traffic checked against the model
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 7) == 0) if_pc = {$urandom, $urandom};
      else                           if_pc = 64'($urandom_range(0, 511)) * 64'd4;
      if_ir = $urandom;
      if ($urandom_range(0, 1) == 1) if_ir[6:0] = 7'b1100011;
      ex_valid    = ($urandom_range(0, 2) != 0);
      ex_pc       = 64'($urandom_range(0, 511)) * 64'd4;
      ex_pr_taken = 1'($urandom_range(0, 1));
      ex_pr_miss  = ($urandom_range(0, 3) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      tick();
    end
    rst = 1'b0;
    ex_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
